// File: rtl/run_scheduler.sv
// Arbitrates two four-phase requesters onto one core: init, launch, run with
// an ack-or-timeout bound, then a done handshake back to the granted requester.
module run_scheduler #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 16'd1000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqA,
  input  logic        ReqB,
  input  logic [1:0]  PgmA,
  input  logic [1:0]  PgmB,
  output logic        CpuInit,
  output logic        CpuStart,
  output logic [1:0]  CpuPgm,
  input  logic        CpuAck,
  output logic        DoneA,
  output logic        DoneB,
  output logic        TimedOut,
  output logic [15:0] CycleCount,
  output logic        Owner
);

  typedef enum logic [2:0] {IDLE, INIT, LAUNCH, RUN, DONE} state_t;

  localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state, state_next;
  logic [3:0]  init_cnt;
  logic [15:0] run_cnt;
  logic        last_served;
  logic        done_first;
  logic        any_req;
  logic        grant_b;
  logic        owner_req;
  logic        run_timeout;

  assign any_req     = ReqA | ReqB;
  // On a tie the requester not served last wins.
  assign grant_b     = (ReqA && ReqB) ? ~last_served : ReqB;
  assign owner_req   = Owner ? ReqB : ReqA;
  assign run_timeout = ((run_cnt + 16'd1) == TIMEOUT_W);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Done stays up on the first DONE cycle even if the request was withdrawn mid-run.
  always_comb begin
    state_next = state;
    CpuInit    = 1'b1;
    CpuStart   = 1'b0;
    DoneA      = 1'b0;
    DoneB      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = INIT;
      end
      INIT: begin
        CpuStart = 1'b1;
        if (init_cnt == INIT_LAST) state_next = LAUNCH;
      end
      LAUNCH: begin
        CpuInit    = 1'b0;
        CpuStart   = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        CpuInit = 1'b0;
        if (CpuAck || run_timeout) state_next = DONE;
      end
      DONE: begin
        DoneA = ~Owner & (ReqA | done_first);
        DoneB =  Owner & (ReqB | done_first);
        if (!owner_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      init_cnt    <= 4'd0;
      run_cnt     <= 16'd0;
      last_served <= 1'b1;
      done_first  <= 1'b0;
      Owner       <= 1'b0;
      CpuPgm      <= 2'd0;
      CycleCount  <= 16'd0;
      TimedOut    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            Owner       <= grant_b;
            last_served <= grant_b;
            CpuPgm      <= grant_b ? PgmB : PgmA;
            init_cnt    <= 4'd0;
          end
        end
        INIT:   init_cnt <= init_cnt + 4'd1;
        LAUNCH: run_cnt  <= 16'd0;
        RUN: begin
          // The counter holds at TIMEOUT-1 on abort, so it never reaches or wraps past TIMEOUT.
          if (CpuAck) begin
            CycleCount <= run_cnt;
            TimedOut   <= 1'b0;
            done_first <= 1'b1;
          end else if (run_timeout) begin
            CycleCount <= TIMEOUT_W;
            TimedOut   <= 1'b1;
            done_first <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 16'd1;
          end
        end
        DONE:    done_first <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_scheduler.sv
// Directed bench for run_scheduler: a timeline model compared every cycle,
// plus literal expectations for each scenario.
module tb_run_scheduler;

  localparam int N  = 2;
  localparam int TO = 10;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ReqA = 1'b0, ReqB = 1'b0;
  logic [1:0]  PgmA = 2'd0, PgmB = 2'd0;
  logic        CpuAck = 1'b0;
  logic        CpuInit, CpuStart, DoneA, DoneB, TimedOut, Owner;
  logic [1:0]  CpuPgm;
  logic [15:0] CycleCount;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  run_scheduler #(.INIT_CYCLES(N), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .ReqA(ReqA), .ReqB(ReqB), .PgmA(PgmA), .PgmB(PgmB),
    .CpuInit(CpuInit), .CpuStart(CpuStart), .CpuPgm(CpuPgm), .CpuAck(CpuAck),
    .DoneA(DoneA), .DoneB(DoneB), .TimedOut(TimedOut), .CycleCount(CycleCount),
    .Owner(Owner)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cycle++;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks a granted run as an age since the grant edge.
  // Ages 1..N are init, N+1 is launch, then run cycle k has counter value k.
  bit          mBusy, mOwner, mLast, mEnded, mTo, mPickB;
  logic [1:0]  mPgm;
  logic [15:0] mCc;
  int          mAge, mDoneAge, mK;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mBusy = 0; mOwner = 0; mLast = 1; mEnded = 0; mTo = 0;
      mPgm = 2'd0; mCc = 16'd0; mAge = 0; mDoneAge = 0;
    end else if (!mBusy) begin
      if (ReqA || ReqB) begin
        mPickB = (ReqA && ReqB) ? !mLast : ReqB;
        mOwner = mPickB;
        mLast  = mPickB;
        mPgm   = mPickB ? PgmB : PgmA;
        mBusy  = 1;
        mEnded = 0;
        mAge   = 1;
      end
    end else begin
      if (mEnded) begin
        if (!(mOwner ? ReqB : ReqA)) mBusy = 0;
      end else if (mAge >= N + 2) begin
        mK = mAge - (N + 2);
        if (CpuAck) begin
          mCc = 16'(mK); mTo = 0; mEnded = 1; mDoneAge = mAge + 1;
        end else if (mK + 1 == TO) begin
          mCc = 16'(TO); mTo = 1; mEnded = 1; mDoneAge = mAge + 1;
        end
      end
      mAge++;
    end
  end

  bit eInit, eStart, eDa, eDb, eOd;

  always @(negedge Clk) begin
    eInit = 1; eStart = 0; eDa = 0; eDb = 0;
    if (Reset && mBusy) begin
      if (mEnded) begin
        eOd = (mOwner ? ReqB : ReqA) || (mAge == mDoneAge);
        eDa = !mOwner && eOd;
        eDb = mOwner && eOd;
      end else if (mAge <= N) begin
        eStart = 1;
      end else if (mAge == N + 1) begin
        eInit = 0; eStart = 1;
      end else begin
        eInit = 0;
      end
    end
    checkOutput("cyc_CpuInit", 32'(CpuInit), 32'(eInit));
    checkOutput("cyc_CpuStart", 32'(CpuStart), 32'(eStart));
    checkOutput("cyc_DoneA", 32'(DoneA), 32'(eDa));
    checkOutput("cyc_DoneB", 32'(DoneB), 32'(eDb));
    checkOutput("cyc_CpuPgm", 32'(CpuPgm), 32'(mPgm));
    checkOutput("cyc_Owner", 32'(Owner), 32'(mOwner));
    checkOutput("cyc_CycleCount", 32'(CycleCount), 32'(mCc));
    checkOutput("cyc_TimedOut", 32'(TimedOut), 32'(mTo));
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setReq(input bit who, input logic v);
    if (who) ReqB = v;
    else     ReqA = v;
  endtask

  function automatic logic doneOf(input bit who);
    return who ? DoneB : DoneA;
  endfunction

  // Serves one run for requester 'who'; ackDelay<0 means the core never acks.
  task automatic applyStimulus(input bit who, input int ackDelay, input bit dropEarly,
                               input int holdDone, output int latency,
                               output int initCycles, output int doneCycles);
    int  start;
    bit  found;
    start = cycle; initCycles = 0; doneCycles = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (CpuInit && CpuStart) initCycles++;
      if (!CpuInit && CpuStart) found = 1;
    end
    if (!found) begin
      errors++; checks++;
      $display("[TB] FAIL launch_wait got none expected launch at %0t", $time);
    end
    checkOutput("run_Owner", 32'(Owner), 32'(who));
    tick();
    if (dropEarly) setReq(who, 1'b0);
    if (ackDelay >= 0) begin
      repeat (ackDelay) tick();
      CpuAck = 1'b1;
      tick();
      CpuAck = 1'b0;
    end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (doneOf(who)) found = 1;
    end
    latency = cycle - start;
    if (!found) begin
      errors++; checks++;
      $display("[TB] FAIL done_wait got none expected done at %0t", $time);
      setReq(who, 1'b0);
      return;
    end
    doneCycles = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (doneCycles >= holdDone) setReq(who, 1'b0);
      @(negedge Clk);
      if (doneOf(who)) doneCycles++;
      else break;
    end
  endtask

  task automatic pulseReset();
    Reset = 1'b0;
    repeat (2) tick();
    Reset = 1'b1;
    tick();
  endtask

  int lat, ini, dn;
  bit found;

  initial begin
    $display("[TB] start");
    repeat (2) tick();
    @(negedge Clk);
    checkOutput("rst_CpuInit", 32'(CpuInit), 1);
    checkOutput("rst_CpuStart", 32'(CpuStart), 0);
    checkOutput("rst_Owner", 32'(Owner), 0);
    Reset = 1'b1;
    tick();

    // Single run: program 2, ack on the fifth run cycle, Done held three cycles.
    ReqA = 1'b1; PgmA = 2'd2;
    applyStimulus(0, 4, 0, 3, lat, ini, dn);
    checkOutput("t1_init_cycles", 32'(ini), 2);
    checkOutput("t1_CycleCount", 32'(CycleCount), 4);
    checkOutput("t1_TimedOut", 32'(TimedOut), 0);
    checkOutput("t1_CpuPgm", 32'(CpuPgm), 2);
    checkOutput("t1_done_cycles", 32'(dn), 3);
    tick();

    // Timeout: the core never acks, nine counting cycles then the abort cycle.
    ReqB = 1'b1; PgmB = 2'd1;
    applyStimulus(1, -1, 0, 2, lat, ini, dn);
    checkOutput("t2_CycleCount", 32'(CycleCount), 10);
    checkOutput("t2_TimedOut", 32'(TimedOut), 1);
    checkOutput("t2_Owner", 32'(Owner), 1);
    tick();

    // Withdrawal during the run still yields a single-cycle Done.
    ReqB = 1'b1; PgmB = 2'd3;
    applyStimulus(1, 3, 1, 5, lat, ini, dn);
    checkOutput("t3_done_cycles", 32'(dn), 1);
    checkOutput("t3_CycleCount", 32'(CycleCount), 3);
    checkOutput("t3_TimedOut", 32'(TimedOut), 0);
    tick();

    // Immediate ack gives the minimum grant-to-done latency.
    ReqA = 1'b1; PgmA = 2'd1;
    applyStimulus(0, 0, 0, 1, lat, ini, dn);
    checkOutput("t4_latency", 32'(lat), N + 3);
    checkOutput("t4_CycleCount", 32'(CycleCount), 0);
    checkOutput("t4_CpuPgm", 32'(CpuPgm), 1);
    tick();

    // Ties after a fresh reset: A, then pending B, then A wins the next tie.
    pulseReset();
    ReqA = 1'b1; ReqB = 1'b1; PgmA = 2'd1; PgmB = 2'd3;
    applyStimulus(0, 1, 0, 2, lat, ini, dn);
    checkOutput("tie1_CpuPgm", 32'(CpuPgm), 1);
    applyStimulus(1, 2, 0, 2, lat, ini, dn);
    checkOutput("tie1_B_Owner", 32'(Owner), 1);
    checkOutput("tie1_B_CpuPgm", 32'(CpuPgm), 3);
    tick();
    ReqA = 1'b1; ReqB = 1'b1; PgmA = 2'd2; PgmB = 2'd1;
    applyStimulus(0, 5, 0, 1, lat, ini, dn);
    checkOutput("tie2_A_CpuPgm", 32'(CpuPgm), 2);
    applyStimulus(1, -1, 0, 1, lat, ini, dn);
    checkOutput("tie2_B_TimedOut", 32'(TimedOut), 1);
    tick();

    // Reset asserted mid-run, between clock edges, with the counter at 3.
    ReqB = 1'b1; PgmB = 2'd3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge Clk);
      if (!CpuInit && CpuStart) found = 1;
    end
    checkOutput("rr_launch_seen", 32'(found), 1);
    repeat (4) tick();
    #2 Reset = 1'b0;
    #1;
    checkOutput("rr_CpuInit", 32'(CpuInit), 1);
    checkOutput("rr_CpuStart", 32'(CpuStart), 0);
    checkOutput("rr_DoneB", 32'(DoneB), 0);
    checkOutput("rr_CpuPgm", 32'(CpuPgm), 0);
    checkOutput("rr_Owner", 32'(Owner), 0);
    checkOutput("rr_CycleCount", 32'(CycleCount), 0);
    checkOutput("rr_TimedOut", 32'(TimedOut), 0);
    ReqB = 1'b0;
    repeat (2) tick();
    Reset = 1'b1;
    tick();
    ReqA = 1'b1; PgmA = 2'd2;
    applyStimulus(0, 2, 0, 2, lat, ini, dn);
    checkOutput("rr_after_CycleCount", 32'(CycleCount), 2);
    checkOutput("rr_after_latency", 32'(lat), N + 5);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
